// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the EX-stage ALU with iterative multiply/divide.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_MUL, OP_DIVU, OP_REMU, OP_ILL
  } alu_op_e;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef logic [1:0] state_e;
  localparam state_e IDLE = 2'd0;
  localparam state_e CALC = 2'd1;
  localparam state_e DONE = 2'd2;

  function automatic logic is_iter(input alu_op_e op);
    return op inside {OP_MUL, OP_DIVU, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared XLEN-step datapath: shift-add multiply or restoring unsigned divide.
module alu_iter_muldiv
  import alu_exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int unsigned CW = $clog2(XLEN);

  logic            active_q, is_mul_q, want_rem_q;
  logic [CW-1:0]   cnt_q;
  // hi: accumulator / partial remainder; lo: multiplier / dividend-then-quotient; b: mcand / divisor
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [XLEN-1:0] hi_d, lo_d, b_d;
  logic [XLEN:0]   r_sh, diff;

  always_comb begin
    r_sh = {hi_q, lo_q[XLEN-1]};
    diff = r_sh - {1'b0, b_q};
    if (is_mul_q) begin
      hi_d = lo_q[0] ? hi_q + b_q : hi_q;
      lo_d = lo_q >> 1;
      b_d  = b_q << 1;
    end else begin
      b_d = b_q;
      if (!diff[XLEN]) begin
        hi_d = diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = r_sh[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Final step result is forwarded combinationally so the top captures it on the XLEN-th edge.
  assign done = active_q && (cnt_q == CW'(XLEN - 1));
  assign res  = (is_mul_q || want_rem_q) ? hi_d : lo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      is_mul_q   <= 1'b0;
      want_rem_q <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      b_q        <= '0;
    end else if (start) begin
      active_q   <= 1'b1;
      is_mul_q   <= (op == OP_MUL);
      want_rem_q <= (op == OP_REMU);
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= (op == OP_MUL) ? b : a;
      b_q        <= (op == OP_MUL) ? a : b;
    end else if (active_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_mc.sv
// EX-stage ALU: decodes ALUOp/funct3/funct7, executes single-cycle or iterative ops, registers result.
module alu_exec_mc
  import alu_exec_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);
  localparam int unsigned SHW = $clog2(XLEN);

  function automatic alu_op_e decode(input logic [1:0] aop, input logic [2:0] f3,
                                     input logic [6:0] f7);
    logic    rtype;
    alu_op_e op;
    rtype = (aop == ALUOP_RTYPE);
    op    = OP_ADD;
    if (aop == ALUOP_MEM) begin
      op = OP_ADD;
    end else if (aop == ALUOP_BRANCH) begin
      op = OP_SUB;
    end else if (rtype && f7 == F7_MULDIV) begin
      if (!MUL_EN) op = OP_ILL;
      else begin
        case (f3)
          3'b000:  op = OP_MUL;
          3'b101:  op = OP_DIVU;
          3'b111:  op = OP_REMU;
          default: op = OP_ILL;
        endcase
      end
    end else if (rtype && f7 != F7_BASE && f7 != F7_ALT) begin
      op = OP_ILL;
    end else if (rtype && f7[5] && f3 != 3'b000 && f3 != 3'b101) begin
      op = OP_ILL;
    end else begin
      // I-type ignores f7 except bit 5 on the right-shift encoding (SRAI).
      case (f3)
        3'b000:  op = (rtype && f7[5]) ? OP_SUB : OP_ADD;
        3'b001:  op = OP_SLL;
        3'b010:  op = OP_SLT;
        3'b011:  op = OP_SLTU;
        3'b100:  op = OP_XOR;
        3'b101:  op = f7[5] ? OP_SRA : OP_SRL;
        3'b110:  op = OP_OR;
        default: op = OP_AND;
      endcase
    end
    return op;
  endfunction

  state_e          state_q;
  logic [XLEN-1:0] result_q, alu_res, md_res;
  logic            illegal_q, accept, md_done, dec_iter;
  alu_op_e         dec_op;
  logic [SHW-1:0]  shamt;

  assign dec_op   = decode(alu_op, funct3, funct7);
  assign dec_iter = is_iter(dec_op);
  assign shamt    = op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (dec_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      default: alu_res = '0;
    endcase
  end

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign illegal   = illegal_q;

  alu_iter_muldiv #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && dec_iter),
    .op    (dec_op),
    .a     (op_a),
    .b     (op_b),
    .done  (md_done),
    .res   (md_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      if (dec_iter) begin
        state_q <= CALC;
      end else begin
        state_q   <= DONE;
        result_q  <= alu_res;
        illegal_q <= (dec_op == OP_ILL);
      end
    end else if (state_q == CALC && md_done) begin
      state_q   <= DONE;
      result_q  <= md_res;
      illegal_q <= 1'b0;
    end else if (state_q == DONE && out_ready) begin
      state_q <= IDLE;
    end
  end

endmodule

// File: tb/tb_alu_exec_mc.sv
// Scoreboard bench for alu_exec_mc: directed corner cases plus randomized traffic.
module tb_alu_exec_mc;

  typedef struct {
    logic [31:0] res;
    bit          ill;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero, illegal, busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   ready_mode = 1'b0;
  bit   ready_val  = 1'b1;
  exp_t sb[$];

  bit          seen = 1'b0;
  logic [31:0] held_res;
  logic        held_ill;

  alu_exec_mc #(
    .XLEN   (32),
    .MUL_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_val;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the instruction semantics.
  function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit ill, output bit iter);
    bit rtype;
    rtype = (op == 2'b10);
    ill = 0; iter = 0; r = '0;
    if (op == 2'b00) r = a + b;
    else if (op == 2'b01) r = a - b;
    else if (rtype && f7 == 7'h01) begin
      iter = 1;
      case (f3)
        3'd0: r = a * b;
        3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd7: r = (b == 0) ? a : a % b;
        default: begin ill = 1; iter = 0; end
      endcase
    end else if (rtype && f7 != 7'h00 && f7 != 7'h20) ill = 1;
    else if (rtype && f7[5] && f3 != 3'd0 && f3 != 3'd5) ill = 1;
    else begin
      case (f3)
        3'd0: r = (rtype && f7[5]) ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: begin
          if (f7[5]) r = $signed(a) >>> b[4:0];
          else r = a >> b[4:0];
        end
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
    if (ill) r = '0;
  endfunction

  // Call at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    bit ill, it, got;
    alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model(op, f3, f7, a, b, r, ill, it);
        sb.push_back('{res: r, ill: ill, due: cyc + 1 + (it ? 32 : 0)});
        got = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: in_ready never rose, expected acceptance");
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) ok = 1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_output: got result %0h, expected no output", result);
        end else begin
          check("result", result, sb[0].res);
          check("illegal", illegal, sb[0].ill);
          check("zero", zero, sb[0].res == 0);
          check("latency", cyc, sb[0].due);
        end
        seen = 1'b1; held_res = result; held_ill = illegal;
      end else begin
        check("hold_result", result, held_res);
        check("hold_illegal", illegal, held_ill);
      end
      if (out_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        seen = 1'b0;
      end
    end
  end

  initial begin
    int nb, nv;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_illegal", illegal, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(2'b10, 3'b000, 7'h20, 32'd5, 32'd7);
    wait_idle();

    issue(2'b10, 3'b000, 7'h01, 32'h1234, 32'h10);
    nb = 0;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("mul_busy_cycles", nb, 32);
    wait_idle();

    issue(2'b10, 3'b101, 7'h01, 32'd100, 32'd0);
    issue(2'b10, 3'b111, 7'h01, 32'd100, 32'd0);
    wait_idle();

    ready_val = 1'b0;
    issue(2'b10, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("held_out_valid", out_valid, 1);
      check("held_in_ready", in_ready, 0);
    end
    ready_val = 1'b1;
    wait_idle();

    for (int i = 0; i < 8; i++) issue(2'b00, 3'($urandom), 7'($urandom), $urandom, $urandom);
    wait_idle();

    issue(2'b10, 3'b000, 7'b0000011, 32'd9, 32'd3);
    wait_idle();

    issue(2'b10, 3'b000, 7'h01, 32'hDEAD, 32'hBEEF);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_result", result, 0);
    check("midrst_zero", zero, 1);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("midrst_no_output", nv, 0);
    @(posedge clk); #1;

    ready_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [6:0]  f7;
      logic [31:0] a, b;
      case ($urandom_range(0, 4))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2, 3: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 40));
        2: a = 32'($urandom_range(0, 300));
        default: ;
      endcase
      issue(2'($urandom), 3'($urandom), f7, a, b);
    end
    ready_mode = 1'b0;
    ready_val  = 1'b1;
    wait_idle();
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
